fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the control unit / datapath. Holds the fetch PC and
//  issues one-outstanding word requests to instruction memory. Buffers returned words in a small
//  prefetch FIFO and presents {Instr, PC, PCPlus8} to decode.
//  Applies redirects from PCSrc/BranchTarget: flushes the FIFO and squashes any in-flight response.
// PARAMETERS
//  ADDR_W    32  fetch address / PC width
//  BUF_DEPTH 2   prefetch FIFO entries (power of 2, >=2)
//  RESET_PC  0   fetch address after reset
// PORTS
//  CLK           in   1       clock, rising edge
//  Reset         in   1       synchronous, active-high
//  PCSrc         in   1       redirect request from control unit
//  BranchTarget  in   ADDR_W  redirect address (ALU result); low 2 bits ignored
//  Stall         in   1       decode cannot accept head entry this cycle
//  IMemReq       out  1       request valid; held stable until IMemAck
//  IMemAddr      out  ADDR_W  word-aligned request address
//  IMemAck       in   1       response valid (same cycle as IMemReq allowed)
//  IMemRData     in   32      response word
//  InstrValid    out  1       head entry valid
//  Instr         out  32      head instruction (0 when !InstrValid)
//  PC            out  ADDR_W  address of head instruction
//  PCPlus8       out  ADDR_W  PC + 8 (ARM-visible PC), modulo 2^ADDR_W
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, fetchPC=RESET_PC, IMemReq=0, IMemAddr=RESET_PC, InstrValid=0,
//    Instr=0, PC=0, PCPlus8=8.
//  - FSM states: IDLE (nothing outstanding), WAIT (live request), KILL (squashed request).
//    IMemReq = (state != IDLE).
//  - IDLE->WAIT when room (count < BUF_DEPTH) and !PCSrc; IMemAddr<=fetchPC, fetchPC<=fetchPC+4.
//  - WAIT & IMemAck & !PCSrc: push {IMemRData, IMemAddr}. Go to WAIT with the next address if
//    count_after_push < BUF_DEPTH, else IDLE. Gives 1 instr/cycle with zero-wait memory.
//  - WAIT & !IMemAck & PCSrc -> KILL; KILL & IMemAck -> IDLE, data dropped.
//  - Pop when InstrValid & !Stall. Push and pop in the same cycle are legal, including when full.
//  - Redirect (PCSrc sampled high at a clock edge):
//    - FIFO flushed; any pop that cycle is void.
//    - fetchPC <= {BranchTarget[ADDR_W-1:2], 2'b00}.
//    - Ack in the same cycle: data dropped, state -> IDLE.
//  - PCSrc beats Stall and push. A PCSrc while in KILL retargets fetchPC only.
//  - The first request after a redirect is issued no earlier than the cycle after the squash
//    completes.
//  - IMemAck while IDLE is ignored; covers stray acks after reset.
//  - Reset mid-operation: everything returns to reset values next edge; no entry survives.
//  - PC arithmetic wraps modulo 2^ADDR_W; 0xFFFFFFFC+4 = 0x0.
//  - Latency: reset low at cycle 0 -> IMemReq high cycle 1 -> with ack in cycle 1, InstrValid cycle 2.
// STRUCTURE
//  - Package fetch_pkg holds:
//    - fetch_state_t enum {IDLE, WAIT, KILL}
//    - fetch_entry_t struct {logic [31:0] instr; logic [ADDR_W-1:0] pc;}
//    - INSTR_BYTES = 4
//    - PC_READ_OFFSET = 8
//  - Sub-module fetch_fifo: BUF_DEPTH x fetch_entry_t, push/pop/flush, count, full/empty.
//    Flush has priority over push.
//  - FSM, PC register and output muxing live in the top module.
// TESTING
//  1. Reset, zero-wait memory, Stall=0 -> IMemAddr 0x0,0x4,0x8 on cycles 1,2,3; InstrValid from
//     cycle 2; PCPlus8 = PC+8.
//  2. Stall held 5 cycles from cycle 3 -> count reaches 2, IMemReq drops. Release -> instructions
//     continue in order, none lost or duplicated.
//  3. Ack delayed 3 cycles, PCSrc=1 with BranchTarget=0x100 while WAIT -> KILL. Late ack data is
//     never shown; next IMemAddr=0x100; InstrValid=0 until its ack.
//  4. PCSrc=1 with BranchTarget=0x103 in the same cycle as IMemAck -> word dropped, FIFO empty next
//     cycle. Next request is IMemAddr=0x100.
//  5. Reset pulsed while WAIT, then ack arrives -> all outputs at reset values, stray ack ignored,
//     next request at RESET_PC.
//  6. BranchTarget=0xFFFFFFFC -> requests 0xFFFFFFFC then 0x00000000; PCPlus8 for head=0x00000004.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// fetch_entry_t.pc uses FETCH_ADDR_W, so fetch_unit's ADDR_W is expected to match it.
package fetch_pkg;

    localparam int FETCH_ADDR_W   = 32;
    localparam int INSTR_BYTES    = 4;
    localparam int PC_READ_OFFSET = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]             instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through prefetch buffer of fetch entries.
// Flush beats push; a push into a full buffer is accepted only alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;
    fetch_entry_t     ram_q [DEPTH];

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            ram_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = ram_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding memory request FSM,
// prefetch buffer and redirect/squash handling in front of decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = FETCH_ADDR_W,
    parameter int                BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Stall,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemAck,
    input  logic [31:0]       IMemRData,
    output logic              InstrValid,
    output logic [31:0]       Instr,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus8
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] next_pc;
    logic [CNT_W-1:0]  count_after_push;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign redirect_pc = BranchTarget & ~ADDR_W'(3);
    assign next_pc     = fetch_pc_q + ADDR_W'(INSTR_BYTES);

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        addr_d           = addr_q;
        fifo_push        = 1'b0;
        fifo_flush       = PCSrc;
        // a redirect voids any pop in the same cycle
        fifo_pop         = !fifo_empty && !Stall && !PCSrc;
        push_entry.instr = IMemRData;
        push_entry.pc    = addr_q;
        count_after_push = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);

        case (state_q)
            IDLE: begin
                if (PCSrc) begin
                    fetch_pc_d = redirect_pc;
                end else if (!fifo_full) begin
                    state_d    = WAIT;
                    addr_d     = fetch_pc_q;
                    fetch_pc_d = next_pc;
                end
            end
            WAIT: begin
                if (PCSrc) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = IMemAck ? IDLE : KILL;
                end else if (IMemAck) begin
                    fifo_push = 1'b1;
                    if (count_after_push < CNT_W'(BUF_DEPTH)) begin
                        addr_d     = fetch_pc_q;
                        fetch_pc_d = next_pc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            KILL: begin
                if (PCSrc) begin
                    fetch_pc_d = redirect_pc;
                end
                if (IMemAck) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .srst     (Reset),
        .push     (fifo_push),
        .push_data(push_entry),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .head     (head_entry),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign IMemReq    = (state_q != IDLE);
    assign IMemAddr   = addr_q;
    assign InstrValid = !fifo_empty;
    assign Instr      = fifo_empty ? 32'd0 : head_entry.instr;
    assign PC         = fifo_empty ? '0 : head_entry.pc;
    assign PCPlus8    = PC + ADDR_W'(PC_READ_OFFSET);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the bench plays instruction memory and checks
// decode-side output against a queue model of accepted fetches.
module tb_fetch_unit;

    localparam int BUF_DEPTH = 2;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        Stall = 1'b0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemRData = '0;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus8;

    fetch_unit #(
        .ADDR_W   (32),
        .BUF_DEPTH(BUF_DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .PCSrc       (PCSrc),
        .BranchTarget(BranchTarget),
        .Stall       (Stall),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemAck     (IMemAck),
        .IMemRData   (IMemRData),
        .InstrValid  (InstrValid),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus8     (PCPlus8)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    logic [31:0] q[$];          // addresses of fetched words decode has yet to take
    logic        in_flight;
    logic        live;
    logic [31:0] cur_addr;
    logic [31:0] exp_next_req;
    int          exp_req_next;  // -1 don't care, else required IMemReq
    int          wait_left;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        in_flight    = 1'b0;
        live         = 1'b0;
        exp_next_req = 32'h0;
        exp_req_next = 0;
        wait_left    = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   64'(IMemReq),    64'(0));
        check_eq({tag, "_addr"},  64'(IMemAddr),   64'(0));
        check_eq({tag, "_valid"}, 64'(InstrValid), 64'(0));
        check_eq({tag, "_instr"}, 64'(Instr),      64'(0));
        check_eq({tag, "_pc"},    64'(PC),         64'(0));
        check_eq({tag, "_pc8"},   64'(PCPlus8),    64'(8));
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        PCSrc   = 1'b0;
        Stall   = 1'b0;
        IMemAck = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        Reset = 1'b0;
        check_reset_outputs("reset");
    endtask

    // One clock: check current outputs, drive inputs, advance the model, cross the edge.
    // ack_mode: 0 never ack, 1 always ack (stray acks while idle too), 2 random delay.
    task automatic run_cycle(input logic stall_i, input logic pcsrc_i,
                             input logic [31:0] tgt_i, input int ack_mode);
        logic ack;
        logic acked;
        logic pop;
        if (exp_req_next >= 0) check_eq("req_after", 64'(IMemReq), 64'(exp_req_next));
        exp_req_next = -1;
        check_eq("valid", 64'(InstrValid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check_eq("pc",    64'(PC),      64'(q[0]));
            check_eq("instr", 64'(Instr),   64'(mem_word(q[0])));
            check_eq("pc8",   64'(PCPlus8), 64'(32'(q[0] + 32'd8)));
        end else begin
            check_eq("instr_idle", 64'(Instr), 64'(0));
        end
        if (IMemReq) begin
            if (!in_flight) begin
                check_eq("req_addr", 64'(IMemAddr), 64'(exp_next_req));
                in_flight = 1'b1;
                live      = 1'b1;
                cur_addr  = IMemAddr;
                wait_left = (ack_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            end else begin
                check_eq("req_hold", 64'(IMemAddr), 64'(cur_addr));
            end
        end else if (in_flight) begin
            check_eq("req_drop", 64'(IMemReq), 64'(1));
            in_flight = 1'b0;
        end

        if (ack_mode == 0) begin
            ack = 1'b0;
        end else if (ack_mode == 1) begin
            ack = 1'b1;
        end else if (IMemReq) begin
            ack = (wait_left == 0);
            if (!ack) wait_left--;
        end else begin
            ack = ($urandom_range(0, 9) == 0);
        end
        IMemAck      = ack;
        IMemRData    = (ack && IMemReq) ? mem_word(IMemAddr) : $urandom;
        Stall        = stall_i;
        PCSrc        = pcsrc_i;
        BranchTarget = tgt_i;

        pop   = (q.size() != 0) && !stall_i;
        acked = IMemReq && ack;
        if (Reset) begin
            model_reset();
        end else begin
            if (acked) in_flight = 1'b0;
            if (pcsrc_i) begin
                q.delete();
                exp_next_req = {tgt_i[31:2], 2'b00};
                if (in_flight) begin
                    live         = 1'b0;
                    exp_req_next = 1;
                end else begin
                    exp_req_next = 0;
                end
            end else begin
                if (pop) begin
                    void'(q.pop_front());
                    pops++;
                end
                if (acked && live) begin
                    q.push_back(cur_addr);
                    exp_next_req = 32'(cur_addr + 32'd4);
                end
                if (acked && !live) exp_req_next = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        model_reset();

        // zero-wait streaming from reset, then a long stall that fills the buffer
        do_reset();
        run_cycle(1'b0, 1'b0, 32'h0, 1);
        check_eq("t1_c1_req",  64'(IMemReq),  64'(1));
        check_eq("t1_c1_addr", 64'(IMemAddr), 64'(32'h0));
        run_cycle(1'b0, 1'b0, 32'h0, 1);
        check_eq("t1_c2_addr",  64'(IMemAddr),   64'(32'h4));
        check_eq("t1_c2_valid", 64'(InstrValid), 64'(1));
        check_eq("t1_c2_pc8",   64'(PCPlus8),    64'(32'h8));
        run_cycle(1'b0, 1'b0, 32'h0, 1);
        check_eq("t1_c3_addr", 64'(IMemAddr), 64'(32'h8));
        for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 32'h0, 1);
        check_eq("t2_req_drop", 64'(IMemReq), 64'(0));
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 32'h0, 1);

        // redirect while the request waits for a slow ack
        do_reset();
        run_cycle(1'b0, 1'b0, 32'h0, 0);
        run_cycle(1'b0, 1'b0, 32'h0, 0);
        run_cycle(1'b0, 1'b1, 32'h100, 0);
        check_eq("t3_kill_req", 64'(IMemReq), 64'(1));
        run_cycle(1'b0, 1'b0, 32'h0, 0);
        run_cycle(1'b0, 1'b0, 32'h0, 1);
        run_cycle(1'b0, 1'b0, 32'h0, 0);
        check_eq("t3_new_addr", 64'(IMemAddr), 64'(32'h100));
        run_cycle(1'b0, 1'b0, 32'h0, 0);
        run_cycle(1'b0, 1'b0, 32'h0, 0);
        check_eq("t3_no_valid", 64'(InstrValid), 64'(0));
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 32'h0, 1);

        // redirect in the same cycle as an ack
        run_cycle(1'b0, 1'b1, 32'h103, 1);
        check_eq("t4_empty", 64'(InstrValid), 64'(0));
        check_eq("t4_idle",  64'(IMemReq),    64'(0));
        run_cycle(1'b0, 1'b0, 32'h0, 1);
        check_eq("t4_addr", 64'(IMemAddr), 64'(32'h100));

        // reset while a request is outstanding, acks arrive during and after reset
        run_cycle(1'b0, 1'b0, 32'h0, 0);
        Reset = 1'b1;
        run_cycle(1'b0, 1'b0, 32'h0, 0);
        run_cycle(1'b0, 1'b0, 32'h0, 1);
        Reset = 1'b0;
        check_reset_outputs("t5");
        run_cycle(1'b0, 1'b0, 32'h0, 1);
        check_eq("t5_addr", 64'(IMemAddr), 64'(32'h0));
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 32'h0, 1);

        // address wrap at the top of memory
        run_cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1);
        run_cycle(1'b0, 1'b0, 32'h0, 1);
        check_eq("t6_addr_top", 64'(IMemAddr), 64'(32'hFFFF_FFFC));
        run_cycle(1'b0, 1'b0, 32'h0, 1);
        check_eq("t6_addr_wrap", 64'(IMemAddr), 64'(32'h0));
        check_eq("t6_pc",        64'(PC),       64'(32'hFFFF_FFFC));
        check_eq("t6_pc8",       64'(PCPlus8),  64'(32'h4));
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 32'h0, 1);

        // random traffic: stalls, ack delays, redirects, stray acks and reset pulses
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            Reset = ($urandom_range(0, 299) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : ($urandom & 32'h0000_0FFF);
            run_cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, tgt, 2);
        end
        Reset = 1'b0;
        check_eq("progress", 64'(pops > 200), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
